mac_lane_acc: RTL and testbench
===============================

// Module: mac_lane_acc
// PURPOSE
//  Multi-lane, pipelined successor of the single-cycle combinational MAC.
//  Each input beat is LANES unsigned activations times LANES stored signed weights, reduced to a dot product.
//  The dot product accumulates over acc_len beats into a signed partial sum.
//  Result is handed off on a valid/ready port. Sits between the activation feeder and the psum/output buffer.
// PARAMETERS
//  BW       4   activation/weight width (activation unsigned, weight signed)
//  PSUM_BW  16  accumulator / out_psum width, signed
//  LANES    4   parallel multiplier lanes
//  CNT_BW   8   width of acc_len and beat counter
// PORTS
//  clk        in   1            clock, rising edge
//  reset_n    in   1            asynchronous, active-low reset
//  w_load     in   1            load w_in into weight regs (honoured only in IDLE)
//  w_in       in   LANES*BW     signed weights, lane i = [i*BW +: BW]
//  in_valid   in   1            activation beat valid
//  in_ready   out  1            block accepts beat
//  a_in       in   LANES*BW     unsigned activations, lane i = [i*BW +: BW]
//  psum_in    in   PSUM_BW      signed initial psum, sampled on first beat
//  acc_len    in   CNT_BW       beats per result, sampled on first beat; 0 treated as 1
//  out_valid  out  1            result valid
//  out_ready  in   1            consumer accepts result
//  out_psum   out  PSUM_BW      signed accumulated result
//  out_ovf    out  1            result overflowed PSUM_BW (sticky per result)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, weights=0, acc=0, cnt=0, stage-1 reg=0.
//    All outputs at reset: in_ready=1, out_valid=0, out_psum=0, out_ovf=0.
//    Reset mid-operation discards the in-flight result.
//  Arithmetic:
//    Product per lane = $signed({1'b0,a}) * $signed(w), 2*BW+1 bits.
//    Dot = sum of lanes, 2*BW+1+$clog2(LANES) bits.
//    Dot is sign-extended to PSUM_BW+1 and added to acc. Overflow occurs when the sum leaves the PSUM_BW signed range.
//  Beat accept: in_valid && in_ready. Stage 1 registers dot. Stage 2 adds the registered dot into acc one cycle later.
//  FSM:
//    IDLE  in_ready=1. On accept: acc<=psum_in, ovf<=0, len<=max(acc_len,1), cnt<=1.
//          Next state is DRAIN if len==1, else ACC.
//    ACC   in_ready=1. Each accept: cnt++. The beat making cnt==len moves to DRAIN. Gaps (in_valid=0) allowed, no effect.
//    DRAIN in_ready=0. Final stage-2 add completes. Next state is OUT.
//    OUT   in_ready=0. out_valid=1; out_psum/out_ovf held stable. On out_ready: next state IDLE, out_valid=0.
//  Latency: last beat accepted at cycle t gives out_valid=1 at t+2. Throughput is len beats per len+2 cycles (no backpressure).
//  Weights: w_load is applied only in IDLE. Weights are updated at the clock edge.
//    An accept in the same IDLE cycle uses the old weights. w_load in any other state is ignored.
//  The first beat's dot adds on top of psum_in, not on top of the previous result.
// CONFIGURATION
//  MAC_SAT_EN defined:
//    On overflow, acc clamps to +2^(PSUM_BW-1)-1 or -2^(PSUM_BW-1). Later beats continue from the clamped value.
//    out_ovf=1.
//  MAC_SAT_EN undefined:
//    acc wraps modulo 2^PSUM_BW (two's complement). out_ovf=1 still set on any wrap.
//  Default build: undefined.
// TESTING (defaults unless noted)
//  1. w=1 all lanes, a=15 all lanes, acc_len=1, psum_in=0
//     -> out_psum=60 at accept+2, out_ovf=0.
//  2. w=-8 all lanes, a=15 all lanes, acc_len=3, psum_in=5, one gap cycle mid-stream
//     -> out_psum=-1435, out_valid 2 cycles after 3rd accept.
//  3. PSUM_BW=10, case-2 weights/activations, psum_in=0, acc_len=3
//     -> with MAC_SAT_EN out_psum=-512, out_ovf=1; without, out_psum=-416, out_ovf=1.
//  4. Result pending, out_ready=0 for 5 cycles
//     -> out_psum stable, in_ready=0, in_valid beats not accepted; out_ready=1 -> IDLE next cycle.
//  5. w_load with w=2 in IDLE, same cycle as accept with old w=1, a=1, acc_len=1
//     -> result 4; next result uses w=2 -> 8. w_load during ACC ignored.
//  6. reset_n low during ACC after 2 of 4 beats
//     -> immediately out_valid=0, in_ready=1, weights 0. A fresh len=1 run with a=1, w=0 gives out_psum=psum_in.

Source files
------------

// File: rtl/mac_lane_acc_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | mac_lane_acc_if : weight-load, activation-beat and result bus of the   |
// |                   lane MAC accumulator.                                |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface mac_lane_acc_if #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int LANES   = 4,
    parameter int CNT_BW  = 8
);
    logic                  w_load;
    logic [LANES*BW-1:0]   w_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*BW-1:0]   a_in;
    logic [PSUM_BW-1:0]    psum_in;
    logic [CNT_BW-1:0]     acc_len;
    logic                  out_valid;
    logic                  out_ready;
    logic [PSUM_BW-1:0]    out_psum;
    logic                  out_ovf;

    modport master (
        output w_load, w_in, in_valid, a_in, psum_in, acc_len, out_ready,
        input  in_ready, out_valid, out_psum, out_ovf
    );

    modport slave (
        input  w_load, w_in, in_valid, a_in, psum_in, acc_len, out_ready,
        output in_ready, out_valid, out_psum, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/mac_lane_acc.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | mac_lane_acc : LANES-wide unsigned-x-signed dot product, registered,   |
// |                then accumulated over acc_len beats into a signed psum. |
// | Option macro MAC_SAT_EN : clamp the accumulator on overflow (else wrap)|
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module mac_lane_acc #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int LANES   = 4,
    parameter int CNT_BW  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    mac_lane_acc_if.slave    bus
);
    localparam int PROD_W = 2*BW + 1;
    localparam int DOT_W  = PROD_W + $clog2(LANES);
    localparam int SUM_W  = PSUM_BW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [LANES*BW-1:0]        w_q;
    logic signed [PSUM_BW-1:0]  acc_q;
    logic                       ovf_q;
    logic [CNT_BW-1:0]          cnt_q;
    logic [CNT_BW-1:0]          len_q;
    logic signed [DOT_W-1:0]    dot_q, dot_d;
    logic                       dv_q;

    logic                       in_ready_w;
    logic                       out_valid_w;
    logic                       accept_w;
    logic [CNT_BW-1:0]          len_first_w;
    logic [CNT_BW-1:0]          cnt_inc_w;
    logic signed [SUM_W-1:0]    sum_w;
    logic                       sum_ovf_w;
    logic signed [PSUM_BW-1:0]  acc_add_w;
    logic signed [PROD_W-1:0]   prod_w [LANES];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [PROD_W-1:0] a_ext;
            logic signed [PROD_W-1:0] w_ext;
            assign a_ext     = $signed({{(PROD_W-BW){1'b0}}, bus.a_in[i*BW +: BW]});
            assign w_ext     = $signed({{(PROD_W-BW){w_q[i*BW+BW-1]}}, w_q[i*BW +: BW]});
            assign prod_w[i] = a_ext * w_ext;
        end
    endgenerate

    always_comb begin
        dot_d = '0;
        for (int i = 0; i < LANES; i++) begin
            dot_d = dot_d + DOT_W'(prod_w[i]);
        end
    end

    // Stage 2: one guard bit above PSUM_BW exposes overflow as a sign disagreement.
    assign sum_w     = SUM_W'(acc_q) + SUM_W'(dot_q);
    assign sum_ovf_w = sum_w[SUM_W-1] ^ sum_w[SUM_W-2];
`ifdef MAC_SAT_EN
    assign acc_add_w = !sum_ovf_w      ? sum_w[PSUM_BW-1:0] :
                       sum_w[SUM_W-1]  ? {1'b1, {(PSUM_BW-1){1'b0}}} :
                                         {1'b0, {(PSUM_BW-1){1'b1}}};
`else
    assign acc_add_w = sum_w[PSUM_BW-1:0];
`endif

    assign len_first_w = (bus.acc_len == '0) ? CNT_BW'(1) : bus.acc_len;
    assign cnt_inc_w   = cnt_q + CNT_BW'(1);
    assign accept_w    = bus.in_valid && in_ready_w;

    always_comb begin
        state_d     = state_q;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_w = 1'b1;
                if (bus.in_valid) begin
                    state_d = (len_first_w == CNT_BW'(1)) ? S_DRAIN : S_ACC;
                end
            end
            S_ACC: begin
                in_ready_w = 1'b1;
                if (bus.in_valid && (cnt_inc_w == len_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid_w = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q   <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
            len_q <= '0;
            dot_q <= '0;
            dv_q  <= 1'b0;
        end else begin
            // Weights change only between results; a same-cycle beat sees the old set.
            if (bus.w_load && (state_q == S_IDLE)) begin
                w_q <= bus.w_in;
            end
            dv_q <= accept_w;
            if (accept_w) begin
                dot_q <= dot_d;
            end
            if (accept_w && (state_q == S_IDLE)) begin
                acc_q <= $signed(bus.psum_in);
                ovf_q <= 1'b0;
                len_q <= len_first_w;
                cnt_q <= CNT_BW'(1);
            end else begin
                if (dv_q) begin
                    acc_q <= acc_add_w;
                    ovf_q <= ovf_q | sum_ovf_w;
                end
                if (accept_w) begin
                    cnt_q <= cnt_inc_w;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_psum  = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_lane_acc.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_mac_lane_acc : directed beats against an integer result model plus  |
// |                   literal expectations for each scenario.              |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_mac_lane_acc;
    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int LANES   = 4;
    localparam int CNT_BW  = 8;
    localparam int PMAX    = (1 << (PSUM_BW-1)) - 1;
    localparam int PMIN    = -(1 << (PSUM_BW-1));

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    mac_lane_acc_if #(.BW(BW), .PSUM_BW(PSUM_BW), .LANES(LANES), .CNT_BW(CNT_BW)) bus ();

    mac_lane_acc #(.BW(BW), .PSUM_BW(PSUM_BW), .LANES(LANES), .CNT_BW(CNT_BW)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int dotp(input logic [LANES*BW-1:0] a, input logic [LANES*BW-1:0] w);
        int s;
        logic [BW-1:0]        av;
        logic signed [BW-1:0] wv;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            av = a[i*BW +: BW];
            wv = w[i*BW +: BW];
            s += int'(av) * int'(wv);
        end
        return s;
    endfunction

    // Result model: integer accumulation, applying range rules after every beat.
    int                  m_acc, m_len, m_cnt, m_vcyc, cyc = 0;
    bit                  m_busy, m_pend, m_ovf, m_idle;
    logic [LANES*BW-1:0] m_w;

    task automatic m_add(input int d);
        int s;
        logic signed [PSUM_BW-1:0] tr;
        s = m_acc + d;
        if (s > PMAX || s < PMIN) begin
            m_ovf = 1'b1;
`ifdef MAC_SAT_EN
            s = (s > PMAX) ? PMAX : PMIN;
`else
            tr = s[PSUM_BW-1:0];
            s  = int'(tr);
`endif
        end
        m_acc = s;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_w = '0; m_busy = 0; m_pend = 0; m_ovf = 0; m_acc = 0;
        end else begin
            m_idle = !m_busy && !m_pend;
            chk("mdl_in_ready", int'(bus.in_ready), int'(!m_pend));
            chk("mdl_out_valid", int'(bus.out_valid), int'(m_pend && cyc >= m_vcyc));
            if (m_pend && cyc >= m_vcyc) begin
                chk("mdl_out_psum", int'($signed(bus.out_psum)), m_acc);
                chk("mdl_out_ovf", int'(bus.out_ovf), int'(m_ovf));
                if (bus.out_ready) m_pend = 0;
            end else if (bus.in_valid && !m_pend) begin
                if (!m_busy) begin
                    m_acc = int'($signed(bus.psum_in));
                    m_ovf = 0;
                    m_len = (bus.acc_len == '0) ? 1 : int'(bus.acc_len);
                    m_cnt = 0;
                    m_busy = 1;
                end
                m_add(dotp(bus.a_in, m_w));
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_busy = 0; m_pend = 1; m_vcyc = cyc + 2;
                end
            end
            if (bus.w_load && m_idle) m_w = bus.w_in;
        end
    end

    task automatic wload(input logic [LANES*BW-1:0] w);
        bus.w_load = 1'b1; bus.w_in = w;
        @(posedge clk); #1;
        bus.w_load = 1'b0;
    endtask

    task automatic send(input logic [LANES*BW-1:0] a, input int p, input int len);
        bit ok;
        ok = 0;
        bus.a_in = a; bus.psum_in = PSUM_BW'(p); bus.acc_len = CNT_BW'(len);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.w_load = 1'b0;
        if (!ok) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic wait_res(input string name, input int exp_psum, input int exp_ovf);
        bit found;
        found = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.out_valid) found = 1;
        end
        if (found) begin
            chk({name, "_psum"}, int'($signed(bus.out_psum)), exp_psum);
            chk({name, "_ovf"}, int'(bus.out_ovf), exp_ovf);
        end else begin
            chk({name, "_timeout"}, 0, 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.w_load = 0; bus.w_in = '0; bus.in_valid = 0; bus.a_in = '0;
        bus.psum_in = '0; bus.acc_len = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_psum", int'(bus.out_psum), 0);
        chk("rst_out_ovf", int'(bus.out_ovf), 0);
        rst_n = 1'b1;

        wload(16'h1111);
        send(16'hFFFF, 0, 1);
        wait_res("single_beat", 60, 0);
        send(16'hFFFF, 7, 0);
        wait_res("len_zero", 67, 0);

        wload(16'h8888);
        send(16'hFFFF, 5, 3);
        send(16'hFFFF, 5, 3);
        @(posedge clk); #1;
        send(16'hFFFF, 5, 3);
        wait_res("neg_gap", -1435, 0);

        send(16'hFFFF, -32500, 3);
        send(16'hFFFF, -32500, 3);
        send(16'hFFFF, -32500, 3);
`ifdef MAC_SAT_EN
        wait_res("neg_ovf", -32768, 1);
`else
        wait_res("neg_ovf", 31596, 1);
`endif

        wload(16'h7777);
        send(16'hFFFF, 32700, 1);
`ifdef MAC_SAT_EN
        wait_res("pos_ovf", 32767, 1);
`else
        wait_res("pos_ovf", -32416, 1);
`endif

        wload(16'h1111);
        bus.out_ready = 1'b0;
        send(16'h2222, 0, 1);
        bus.in_valid = 1'b1; bus.a_in = 16'hFFFF; bus.acc_len = 8'd1;
        repeat (7) @(posedge clk);
        #1;
        chk("hold_in_ready", int'(bus.in_ready), 0);
        chk("hold_out_psum", int'($signed(bus.out_psum)), 8);
        bus.in_valid = 1'b0;
        wait_res("backpressure", 8, 0);
        chk("after_hs_in_ready", int'(bus.in_ready), 1);

        bus.w_load = 1'b1; bus.w_in = 16'h2222;
        send(16'h1111, 0, 1);
        wait_res("wload_same_cycle", 4, 0);
        send(16'h1111, 0, 1);
        wait_res("wload_next", 8, 0);
        send(16'h1111, 0, 2);
        bus.w_load = 1'b1; bus.w_in = 16'h3333;
        send(16'h1111, 0, 2);
        wait_res("wload_in_acc", 16, 0);

        send(16'h1111, 0, 4);
        send(16'h1111, 0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(16'h1111, 123, 1);
        wait_res("post_reset", 123, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
